// File: rtl/po_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : po_pad_pkg
// Description : Shared types and constants for the GPOUT pad output driver:
//               sequencer state encoding, configuration chain length and the
//               bit positions of each configuration field.
// Revision    : 1.0 - initial release
// ============================================================================
package po_pad_pkg;

    // Configuration chain length
    localparam int CFG_W = 4;

    // Bit positions inside the configuration word
    localparam int CFG_REG_MODE = 0;   // 1 = pad data/OE taken from flops
    localparam int CFG_INVERT   = 1;   // invert fabric data
    localparam int CFG_PARK_VAL = 2;   // value driven while parking
    localparam int CFG_OE_FORCE = 3;   // force output enable on

    // Output-enable sequencer state; encoding 3 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_PARK  = 2'd2,
        ST_RSVD  = 2'd3
    } po_state_e;

endpackage : po_pad_pkg
`default_nettype wire

// File: rtl/po_pad_ccff_chain.sv
`default_nettype none
// ============================================================================
// Module      : po_pad_ccff_chain
// Description : Serial configuration shift register. Shifts towards the MSB
//               when enabled; the MSB is the serial output. No reset: the
//               contents change only by shifting.
// Revision    : 1.0 - initial release
// ============================================================================
module po_pad_ccff_chain #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic             i_head,
    output logic             o_tail,
    output logic [WIDTH-1:0] o_cfg
);

    logic [WIDTH-1:0] r_cfg;

    // Shift a new bit in at the LSB whenever the chain is enabled
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_cfg <= {r_cfg[WIDTH-2:0], i_head};
        end
    end

    assign o_tail = r_cfg[WIDTH-1];
    assign o_cfg  = r_cfg;

endmodule : po_pad_ccff_chain
`default_nettype wire

// File: rtl/po_pad_out_driver.sv
`default_nettype none
// ============================================================================
// Module      : po_pad_out_driver
// Description : Fabric-to-pad (F2A) output driver for one GPOUT pad. Holds a
//               scan-capable output flop, a 4-bit configuration chain and an
//               output-enable sequencer that parks the pad at a configured
//               value for PARK_CYC cycles before releasing it to high-Z.
//               Optional macro PO_PAD_SCAN_EN adds the scan mux on the output
//               flop and exposes it on po_pad_sc_out.
// Revision    : 1.0 - initial release
// ============================================================================
module po_pad_out_driver
    import po_pad_pkg::*;
#(
    parameter int PARK_CYC = 2,
    parameter int CFG_W    = po_pad_pkg::CFG_W
) (
    input  logic       po_pad_clk,
    input  logic       po_pad_reset,
    input  logic       SE,
    input  logic       ccff_en,
    input  logic       ccff_head,
    output logic       ccff_tail,
    input  logic       po_pad_f2a_i,
    input  logic       po_pad_oe_i,
    input  logic       po_pad_sc_in,
    output logic       po_pad_sc_out,
    output logic       gfpga_pad_poutput_extmode_F2A,
    output logic       gfpga_pad_poutput_extmode_OE,
    output logic [1:0] po_pad_state_o
);

    // Park counter only needs to hold PARK_CYC-1
    localparam int CNT_W = (PARK_CYC > 2) ? $clog2(PARK_CYC) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'((PARK_CYC > 0) ? (PARK_CYC - 1) : 0);

    logic [CFG_W-1:0] w_cfg;
    logic             w_reg_mode;
    logic             w_invert;
    logic             w_park_val;
    logic             w_oe_force;

    logic             w_d;
    logic             w_q_next;
    logic             w_oe_req;
    logic             w_path;
    logic             w_oe_eff;
    logic             w_freeze;

    logic             r_q;
    logic             r_oe_q;

    po_state_e        r_state;
    po_state_e        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic             w_oe_moore;
    logic             w_f2a_moore;

    // ------------------------------------------------------------------
    // Configuration chain
    // ------------------------------------------------------------------
    po_pad_ccff_chain #(
        .WIDTH (CFG_W)
    ) u_ccff_chain (
        .clk    (po_pad_clk),
        .i_en   (ccff_en),
        .i_head (ccff_head),
        .o_tail (ccff_tail),
        .o_cfg  (w_cfg)
    );

    assign w_reg_mode = w_cfg[CFG_REG_MODE];
    assign w_invert   = w_cfg[CFG_INVERT];
    assign w_park_val = w_cfg[CFG_PARK_VAL];
    assign w_oe_force = w_cfg[CFG_OE_FORCE];

    // ------------------------------------------------------------------
    // Data path
    // ------------------------------------------------------------------
    assign w_d      = po_pad_f2a_i ^ w_invert;
    assign w_oe_req = po_pad_oe_i | w_oe_force;
    assign w_path   = w_reg_mode ? r_q    : w_d;
    assign w_oe_eff = w_reg_mode ? r_oe_q : w_oe_req;

    // Configuration shifting or scan both suspend normal pad operation
    assign w_freeze = ccff_en | SE;

`ifdef PO_PAD_SCAN_EN
    assign w_q_next      = SE ? po_pad_sc_in : w_d;
    assign po_pad_sc_out = r_q;
`else
    logic w_unused_sc_in;
    assign w_unused_sc_in = po_pad_sc_in;
    assign w_q_next       = w_d;
    assign po_pad_sc_out  = 1'b0;
`endif

    // Output data flop and registered output-enable; not affected by freeze
    always_ff @(posedge po_pad_clk) begin
        if (po_pad_reset) begin
            r_q    <= 1'b0;
            r_oe_q <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_oe_q <= w_oe_req;
        end
    end

    // ------------------------------------------------------------------
    // Output-enable sequencer
    // ------------------------------------------------------------------

    // State and park counter; both hold while frozen, reset wins over freeze
    always_ff @(posedge po_pad_clk) begin
        if (po_pad_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (!w_freeze) begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state: re-enable during PARK takes priority over park expiry
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_oe_eff) begin
                    w_state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (!w_oe_eff) begin
                    if (PARK_CYC == 0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_PARK;
                        w_cnt_next   = c_CNT_LOAD;
                    end
                end
            end
            ST_PARK: begin
                if (w_oe_eff) begin
                    w_state_next = ST_DRIVE;
                end else if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Moore pad outputs, forced low while frozen
    always_comb begin
        w_oe_moore  = 1'b0;
        w_f2a_moore = 1'b0;
        case (r_state)
            ST_DRIVE: begin
                w_oe_moore  = 1'b1;
                w_f2a_moore = w_path;
            end
            ST_PARK: begin
                w_oe_moore  = 1'b1;
                w_f2a_moore = w_park_val;
            end
            default: begin
                w_oe_moore  = 1'b0;
                w_f2a_moore = 1'b0;
            end
        endcase
    end

    assign gfpga_pad_poutput_extmode_OE  = w_oe_moore  & ~w_freeze;
    assign gfpga_pad_poutput_extmode_F2A = w_f2a_moore & ~w_freeze;
    assign po_pad_state_o                = r_state;

endmodule : po_pad_out_driver
`default_nettype wire

// File: tb/tb_po_pad_out_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_po_pad_out_driver
// Description : Randomized scoreboard bench for po_pad_out_driver. A stimulus
//               process advances a behavioural pad model and queues the
//               expected outputs of every cycle; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_po_pad_out_driver;

    localparam int PARK_CYC = 2;
    localparam int N_CYC    = 3000;

`ifdef PO_PAD_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       se;
    logic       ccff_en;
    logic       ccff_head;
    logic       ccff_tail;
    logic       f2a_i;
    logic       oe_i;
    logic       sc_in;
    logic       sc_out;
    logic       pad_f2a;
    logic       pad_oe;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    po_pad_out_driver #(
        .PARK_CYC (PARK_CYC)
    ) dut (
        .po_pad_clk                    (clk),
        .po_pad_reset                  (rst),
        .SE                            (se),
        .ccff_en                       (ccff_en),
        .ccff_head                     (ccff_head),
        .ccff_tail                     (ccff_tail),
        .po_pad_f2a_i                  (f2a_i),
        .po_pad_oe_i                   (oe_i),
        .po_pad_sc_in                  (sc_in),
        .po_pad_sc_out                 (sc_out),
        .gfpga_pad_poutput_extmode_F2A (pad_f2a),
        .gfpga_pad_poutput_extmode_OE  (pad_oe),
        .po_pad_state_o                (state_o)
    );

    typedef struct {
        logic       oe;
        logic       f2a;
        logic       sc;
        logic       tail;
        bit         tail_known;
        logic [1:0] st;
    } exp_t;

    exp_t q_exp[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: pad mode 0=off, 1=driving, 2=parking with m_left
    // cycles of parking still to come (including the current one).
    logic [3:0] m_cfg   = 4'b0000;
    logic [3:0] m_known = 4'b0000;
    bit         m_q     = 1'b0;
    bit         m_oeq   = 1'b0;
    int         m_mode  = 0;
    int         m_left  = 0;

    task automatic model_step();
        bit d, oe_req, oe_eff, frz;
        d      = f2a_i ^ m_cfg[1];
        oe_req = oe_i | m_cfg[3];
        oe_eff = m_cfg[0] ? m_oeq : oe_req;
        frz    = ccff_en | se;
        if (rst) begin
            m_mode = 0;
            m_left = 0;
            m_q    = 1'b0;
            m_oeq  = 1'b0;
        end else begin
            m_q   = (SCAN && se) ? sc_in : d;
            m_oeq = oe_req;
            if (!frz) begin
                if (m_mode == 0) begin
                    if (oe_eff) m_mode = 1;
                end else if (m_mode == 1) begin
                    if (!oe_eff) begin
                        if (PARK_CYC == 0) m_mode = 0;
                        else begin
                            m_mode = 2;
                            m_left = PARK_CYC;
                        end
                    end
                end else begin
                    if (oe_eff)           m_mode = 1;
                    else if (m_left <= 1) m_mode = 0;
                    else                  m_left = m_left - 1;
                end
            end
        end
        if (ccff_en) begin
            m_cfg   = {m_cfg[2:0], ccff_head};
            m_known = {m_known[2:0], 1'b1};
        end
    endtask

    task automatic push_expected();
        exp_t e;
        bit   frz, d, path;
        frz  = ccff_en | se;
        d    = f2a_i ^ m_cfg[1];
        path = m_cfg[0] ? m_q : d;
        e.oe         = !frz && (m_mode != 0);
        e.f2a        = frz ? 1'b0 : (m_mode == 1) ? path : (m_mode == 2) ? m_cfg[2] : 1'b0;
        e.sc         = SCAN ? m_q : 1'b0;
        e.tail       = m_cfg[3];
        e.tail_known = m_known[3];
        e.st         = 2'(m_mode);
        q_exp.push_back(e);
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare one expected record per cycle, away from the clock edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk("pad_oe",  {1'b0, pad_oe},  {1'b0, e.oe});
                chk("pad_f2a", {1'b0, pad_f2a}, {1'b0, e.f2a});
                chk("sc_out",  {1'b0, sc_out},  {1'b0, e.sc});
                chk("state_o", state_o,         e.st);
                if (e.tail_known) chk("ccff_tail", {1'b0, ccff_tail}, {1'b0, e.tail});
            end
        end
    end

    // Stimulus
    initial begin
        int cfg_left = 0;
        int se_left  = 0;
        rst       = 1'b1;
        se        = 1'b0;
        ccff_en   = 1'b1;
        ccff_head = 1'($urandom);
        f2a_i     = 1'b0;
        oe_i      = 1'b0;
        sc_in     = 1'b0;

        for (int c = 0; c < N_CYC; c++) begin
            @(posedge clk);
            model_step();
            #1;
            if (c < 6) begin
                rst       = 1'b1;
                ccff_en   = 1'b1;
                ccff_head = 1'($urandom);
            end else if (c < 8) begin
                rst     = 1'b1;
                ccff_en = 1'b0;
            end else begin
                rst = ($urandom_range(0, 149) == 0);
                if (cfg_left == 0 && $urandom_range(0, 119) == 0) cfg_left = 4;
                if (cfg_left > 0) begin
                    ccff_en   = 1'b1;
                    ccff_head = 1'($urandom);
                    cfg_left--;
                end else begin
                    ccff_en = 1'b0;
                end
                if (se_left == 0 && $urandom_range(0, 89) == 0) se_left = $urandom_range(1, 3);
                if (se_left > 0) begin
                    se = 1'b1;
                    se_left--;
                end else begin
                    se = 1'b0;
                end
                if ($urandom_range(0, 3) == 0) oe_i = ~oe_i;
                f2a_i = 1'($urandom);
                sc_in = 1'($urandom);
            end
            push_expected();
        end

        repeat (3) @(negedge clk);
        if (q_exp.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d required=0 records left", q_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_po_pad_out_driver
`default_nettype wire
